ptmch_trg_gen: RTL and testbench

//  Downstream stage of the pattern matcher: turns a 1-cycle MATCH event into the TRG_PLS output.
//  The pulse has a programmable delay, width and re-arm holdoff. Runs on CLK75M.

---
 rtl/ptmch_trg_gen.sv | 133 +++++++++++++
 tb/tb_ptmch_trg_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptmch_trg_gen.sv
// Pattern-matcher trigger stage: MATCH strobe -> delayed, sized TRG_PLS
// with re-arm holdoff, plus saturating trigger/miss counters.
module ptmch_trg_gen #(
    parameter int DLY_W = 16,
    parameter int WID_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLK75M,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             MATCH,
    input  logic [DLY_W-1:0] DELAY_CFG,
    input  logic [WID_W-1:0] WIDTH_CFG,
    input  logic [DLY_W-1:0] HOLD_CFG,
    input  logic             CLR_CNT,
    output logic             TRG_PLS,
    output logic             BUSY,
    output logic [CNT_W-1:0] TRG_CNT,
    output logic [CNT_W-1:0] MISS_CNT
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        PULSE,
        HOLDOFF
    } state_t;

    state_t           state;
    logic [DLY_W-1:0] cnt;
    logic [DLY_W-1:0] wid_m1;
    logic [DLY_W-1:0] hold_q;
    logic [DLY_W-1:0] wid_m1_in;
    logic             cnt_zero;
    logic             accept;
    logic             rise;
    logic             miss;

    // A zero width behaves as one cycle, so its terminal count is also zero
    assign wid_m1_in = (WIDTH_CFG == '0) ? '0
                     : DLY_W'(WIDTH_CFG) - DLY_W'(1);
    assign cnt_zero  = (cnt == '0);
    assign accept    = ENABLE && MATCH && (state == IDLE);
    assign rise      = ENABLE && ((accept && (DELAY_CFG == '0)) ||
                                  ((state == DELAY) && cnt_zero));
    assign miss      = ENABLE && MATCH && (state != IDLE);

    always_ff @(posedge CLK75M or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            wid_m1  <= '0;
            hold_q  <= '0;
            TRG_PLS <= 1'b0;
            BUSY    <= 1'b0;
        end else if (!ENABLE) begin
            state   <= IDLE;
            cnt     <= '0;
            TRG_PLS <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (MATCH) begin
                        wid_m1 <= wid_m1_in;
                        hold_q <= HOLD_CFG;
                        BUSY   <= 1'b1;
                        if (DELAY_CFG == '0) begin
                            state   <= PULSE;
                            TRG_PLS <= 1'b1;
                            cnt     <= wid_m1_in;
                        end else begin
                            state <= DELAY;
                            cnt   <= DELAY_CFG - DLY_W'(1);
                        end
                    end
                end
                DELAY: begin
                    if (cnt_zero) begin
                        state   <= PULSE;
                        TRG_PLS <= 1'b1;
                        cnt     <= wid_m1;
                    end else begin
                        cnt <= cnt - DLY_W'(1);
                    end
                end
                PULSE: begin
                    if (cnt_zero) begin
                        TRG_PLS <= 1'b0;
                        if (hold_q == '0) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state <= HOLDOFF;
                            cnt   <= hold_q - DLY_W'(1);
                        end
                    end else begin
                        cnt <= cnt - DLY_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt_zero) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt <= cnt - DLY_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    TRG_PLS <= 1'b0;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK75M or posedge RESET) begin
        if (RESET) begin
            TRG_CNT  <= '0;
            MISS_CNT <= '0;
        end else if (CLR_CNT) begin
            TRG_CNT  <= '0;
            MISS_CNT <= '0;
        end else begin
            if (rise && (TRG_CNT != '1))
                TRG_CNT <= TRG_CNT + CNT_W'(1);
            if (miss && (MISS_CNT != '1))
                MISS_CNT <= MISS_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ptmch_trg_gen.sv
// Bench for ptmch_trg_gen: per-cycle TRG_PLS/BUSY scoreboard plus
// scenario tasks checking counters, abort, saturation and async reset.
module tb_ptmch_trg_gen;

    logic        CLK75M = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        MATCH;
    logic [15:0] DELAY_CFG;
    logic [15:0] WIDTH_CFG;
    logic [15:0] HOLD_CFG;
    logic        CLR_CNT;
    logic        TRG_PLS;
    logic        BUSY;
    logic [3:0]  TRG_CNT;
    logic [3:0]  MISS_CNT;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        string name;
        int    edge_n;
        logic  pls;
        logic  busy;
    } exp_t;

    exp_t sb_q[$];

    ptmch_trg_gen #(.DLY_W(16), .WID_W(16), .CNT_W(4)) dut (
        .CLK75M   (CLK75M),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .MATCH    (MATCH),
        .DELAY_CFG(DELAY_CFG),
        .WIDTH_CFG(WIDTH_CFG),
        .HOLD_CFG (HOLD_CFG),
        .CLR_CNT  (CLR_CNT),
        .TRG_PLS  (TRG_PLS),
        .BUSY     (BUSY),
        .TRG_CNT  (TRG_CNT),
        .MISS_CNT (MISS_CNT)
    );

    always #5 CLK75M = ~CLK75M;

    // Scoreboard: one expected TRG_PLS/BUSY pair per cycle
    always @(negedge CLK75M) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            vecs++;
            if (TRG_PLS !== e.pls || BUSY !== e.busy) begin
                errs++;
                $display("FAIL %s edge %0d: pls,busy=%b,%b expected %b,%b",
                         e.name, e.edge_n, TRG_PLS, BUSY, e.pls, e.busy);
            end
        end
    end

    task automatic clear_counts();
        CLR_CNT = 1'b1;
        @(posedge CLK75M); #1;
        CLR_CNT = 1'b0;
    endtask

    // Expected waveform follows the documented edge timing of each accept
    task automatic play(input string name, input int d, input int w,
                        input int h, input int mt[$], input int n,
                        output int nacc, output int nmiss);
        bit   mm[];
        bit   ep[];
        bit   eb[];
        int   nf;
        int   wp;
        exp_t e;
        mm = new[n + 2];
        ep = new[n + 1];
        eb = new[n + 1];
        wp = (w == 0) ? 1 : w;
        foreach (mt[i]) mm[mt[i]] = 1'b1;
        nacc  = 0;
        nmiss = 0;
        nf    = 1;
        for (int t = 1; t <= n; t++) begin
            if (mm[t]) begin
                if (t >= nf) begin
                    nacc++;
                    for (int j = t + d; j < t + d + wp && j <= n; j++)
                        ep[j] = 1'b1;
                    for (int j = t; j < t + d + wp + h && j <= n; j++)
                        eb[j] = 1'b1;
                    nf = t + d + wp + h + 1;
                end else begin
                    nmiss++;
                end
            end
        end
        DELAY_CFG = 16'(d);
        WIDTH_CFG = 16'(w);
        HOLD_CFG  = 16'(h);
        for (int j = 0; j <= n; j++) begin
            e.name   = name;
            e.edge_n = j;
            e.pls    = ep[j];
            e.busy   = eb[j];
            sb_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            MATCH = mm[i + 1];
            @(posedge CLK75M); #1;
        end
        MATCH = 1'b0;
        @(negedge CLK75M); #1;
        @(posedge CLK75M); #1;
    endtask

    task automatic test_reset();
        RESET     = 1'b1;
        ENABLE    = 1'b0;
        MATCH     = 1'b0;
        CLR_CNT   = 1'b0;
        DELAY_CFG = '0;
        WIDTH_CFG = '0;
        HOLD_CFG  = '0;
        #12;
        vecs++;
        if (TRG_PLS !== 1'b0 || BUSY !== 1'b0 ||
            TRG_CNT !== 4'd0 || MISS_CNT !== 4'd0) begin
            errs++;
            $display("FAIL reset: pls=%b busy=%b trg=%0d miss=%0d expected 0",
                     TRG_PLS, BUSY, TRG_CNT, MISS_CNT);
        end
        @(negedge CLK75M);
        RESET = 1'b0;
        @(posedge CLK75M); #1;
        ENABLE = 1'b1;
    endtask

    task automatic test_single();
        int na, nm;
        clear_counts();
        play("single", 0, 1, 0, '{1}, 4, na, nm);
        vecs++;
        if (TRG_CNT !== 4'd1 || MISS_CNT !== 4'd0) begin
            errs++;
            $display("FAIL single_cnt: trg=%0d miss=%0d expected 1 0",
                     TRG_CNT, MISS_CNT);
        end
    endtask

    task automatic test_back_to_back();
        int na, nm;
        clear_counts();
        play("delay_hold", 5, 3, 4, '{1, 2, 12, 13, 14}, 28, na, nm);
        vecs++;
        if (TRG_CNT !== 4'd2 || MISS_CNT !== 4'd3) begin
            errs++;
            $display("FAIL b2b_cnt: trg=%0d miss=%0d expected 2 3",
                     TRG_CNT, MISS_CNT);
        end
    endtask

    task automatic test_zero_width();
        int na, nm;
        clear_counts();
        play("zero_width", 2, 0, 0, '{1}, 5, na, nm);
        vecs++;
        if (TRG_CNT !== 4'd1) begin
            errs++;
            $display("FAIL zero_width_cnt: trg=%0d expected 1", TRG_CNT);
        end
    endtask

    task automatic test_abort();
        clear_counts();
        DELAY_CFG = 16'd4;
        WIDTH_CFG = 16'd2;
        HOLD_CFG  = 16'd0;
        MATCH = 1'b1;
        @(posedge CLK75M); #1;
        MATCH = 1'b0;
        vecs++;
        if (BUSY !== 1'b1 || TRG_PLS !== 1'b0) begin
            errs++;
            $display("FAIL abort_arm: busy=%b pls=%b expected 1 0",
                     BUSY, TRG_PLS);
        end
        ENABLE = 1'b0;
        @(posedge CLK75M); #1;
        vecs++;
        if (BUSY !== 1'b0 || TRG_PLS !== 1'b0) begin
            errs++;
            $display("FAIL abort_idle: busy=%b pls=%b expected 0 0",
                     BUSY, TRG_PLS);
        end
        ENABLE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK75M); #1;
            vecs++;
            if (TRG_PLS !== 1'b0 || BUSY !== 1'b0) begin
                errs++;
                $display("FAIL abort_quiet: cyc %0d pls=%b busy=%b expected 0 0",
                         i, TRG_PLS, BUSY);
            end
        end
        vecs++;
        if (TRG_CNT !== 4'd0) begin
            errs++;
            $display("FAIL abort_cnt: trg=%0d expected 0", TRG_CNT);
        end
        DELAY_CFG = 16'd0;
        WIDTH_CFG = 16'd4;
        MATCH = 1'b1;
        @(posedge CLK75M); #1;
        MATCH = 1'b0;
        vecs++;
        if (TRG_PLS !== 1'b1) begin
            errs++;
            $display("FAIL trunc_rise: pls=%b expected 1", TRG_PLS);
        end
        ENABLE = 1'b0;
        @(posedge CLK75M); #1;
        vecs++;
        if (TRG_PLS !== 1'b0 || BUSY !== 1'b0 || TRG_CNT !== 4'd1) begin
            errs++;
            $display("FAIL trunc_cut: pls=%b busy=%b trg=%0d expected 0 0 1",
                     TRG_PLS, BUSY, TRG_CNT);
        end
        MATCH = 1'b1;
        @(posedge CLK75M); #1;
        MATCH = 1'b0;
        vecs++;
        if (BUSY !== 1'b0 || MISS_CNT !== 4'd0) begin
            errs++;
            $display("FAIL disabled_match: busy=%b miss=%0d expected 0 0",
                     BUSY, MISS_CNT);
        end
        ENABLE = 1'b1;
        @(posedge CLK75M); #1;
    endtask

    task automatic test_saturate();
        int na, nm;
        int mt[$];
        clear_counts();
        for (int t = 1; t <= 40; t++) mt.push_back(t);
        play("saturate", 0, 1, 0, mt, 41, na, nm);
        vecs++;
        if (TRG_CNT !== 4'd15 || MISS_CNT !== 4'd15) begin
            errs++;
            $display("FAIL saturate: trg=%0d miss=%0d expected 15 15",
                     TRG_CNT, MISS_CNT);
        end
        MATCH   = 1'b1;
        CLR_CNT = 1'b1;
        @(posedge CLK75M); #1;
        MATCH   = 1'b0;
        CLR_CNT = 1'b0;
        vecs++;
        if (TRG_PLS !== 1'b1 || TRG_CNT !== 4'd0 || MISS_CNT !== 4'd0) begin
            errs++;
            $display("FAIL clr_vs_rise: pls=%b trg=%0d miss=%0d expected 1 0 0",
                     TRG_PLS, TRG_CNT, MISS_CNT);
        end
        @(posedge CLK75M); #1;
    endtask

    task automatic test_async_reset();
        DELAY_CFG = 16'd0;
        WIDTH_CFG = 16'd5;
        HOLD_CFG  = 16'd0;
        MATCH = 1'b1;
        @(posedge CLK75M); #1;
        MATCH = 1'b0;
        @(posedge CLK75M); #2;
        vecs++;
        if (TRG_PLS !== 1'b1 || TRG_CNT === 4'd0) begin
            errs++;
            $display("FAIL pre_reset: pls=%b trg=%0d expected 1 nonzero",
                     TRG_PLS, TRG_CNT);
        end
        RESET = 1'b1;
        #1;
        vecs++;
        if (TRG_PLS !== 1'b0 || BUSY !== 1'b0 ||
            TRG_CNT !== 4'd0 || MISS_CNT !== 4'd0) begin
            errs++;
            $display("FAIL async_reset: pls=%b busy=%b trg=%0d miss=%0d expected 0",
                     TRG_PLS, BUSY, TRG_CNT, MISS_CNT);
        end
        @(negedge CLK75M);
        RESET = 1'b0;
        @(posedge CLK75M); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_width();
        test_abort();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
